// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU:
// op codes, flag bit positions and controller states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier, one partial product per step.
// product_next exposes the product after the current step.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product_next
);

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign product_next = mplier[0] ? product + mcand : product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (load) begin
            product <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (step) begin
            product <= product_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags and start/busy/done handshake;
// MUL runs WIDTH cycles on the optional iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    state_t             state;
    logic [SW-1:0]      iter;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   bx;
    logic [WIDTH-1:0]   res;
    logic [3:0]         fl;
    logic               cout;
    logic               ovf;
    logic               is_mul;
    logic               accept;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mres;
    logic [3:0]         mfl;

    assign is_mul = (op == OP_MUL) && MUL_EN;
    assign accept = start && (state == IDLE);

    always_comb begin
        bx   = op[0] ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op[0]};
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        unique case (1'b1)
            (op == OP_ADD), (op == OP_SUB): begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                // operand signs agree (after SUB inversion) but sum sign differs
                ovf  = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0])
                     & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            (op == OP_AND): res = a & b;
            (op == OP_ORR): res = a | b;
            (op == OP_EOR): res = a ^ b;
            (op == OP_LSL): res = a << b[SW-1:0];
            (op == OP_LSR): res = a >> b[SW-1:0];
            (op == OP_MUL): res = '0;
            default: res = '0;
        endcase
        fl         = '0;
        fl[FLAG_N] = res[WIDTH-1];
        fl[FLAG_Z] = (res == '0);
        fl[FLAG_C] = cout;
        fl[FLAG_V] = ovf;
    end

    always_comb begin
        mres        = prod_next[WIDTH-1:0];
        mfl         = '0;
        mfl[FLAG_N] = mres[WIDTH-1];
        mfl[FLAG_Z] = (mres == '0);
        mfl[FLAG_C] = |prod_next[2*WIDTH-1:WIDTH];
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH(WIDTH)
            ) u_mul (
                .clk         (clk),
                .reset       (reset),
                .load        (accept && is_mul),
                .step        (state == MUL),
                .a           (a),
                .b           (b),
                .product_next(prod_next)
            );
        end else begin : g_nomul
            assign prod_next = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            iter   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end else begin
                            result <= res;
                            flags  <= fl;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    iter <= iter + 1'b1;
                    // last step: commit the product including this edge's add
                    if (iter == LAST) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        result <= mres;
                        flags  <= mfl;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: random and directed ops against an
// arithmetic reference model, plus a MUL_EN=0 instance.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    logic         start_n = 1'b0;
    logic [2:0]   op_n = '0;
    logic [W-1:0] a_n = '0;
    logic [W-1:0] b_n = '0;
    logic         busy_n;
    logic         done_n;
    logic [W-1:0] result_n;
    logic [3:0]   flags_n;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .flags(flags)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .start(start_n), .op(op_n),
        .a(a_n), .b(b_n), .busy(busy_n), .done(done_n),
        .result(result_n), .flags(flags_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        int           c;
    } exp_t;

    exp_t q[$];
    int   mul_at = -1000;

    function automatic logic [W+3:0] model(input logic [2:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint unsigned ux, uy, p;
        longint sx, sy, s;
        logic [W-1:0] r;
        logic c, v;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        c = 1'b0; v = 1'b0; r = '0;
        case (o)
            3'd0: begin
                p = ux + uy; r = p[W-1:0]; c = (p >> W) != 0;
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = x - y; c = (ux >= uy);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x << y[4:0];
            3'd6: r = x >> y[4:0];
            default: begin
                p = ux * uy; r = p[W-1:0]; c = (p >> W) != 0;
            end
        endcase
        return {r, r[W-1], r == '0, c, v};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        exp_t e;
        logic [W+3:0] m;
        start = 1'b1; op = o; a = x; b = y;
        if (!(cyc > mul_at && cyc <= mul_at + W)) begin
            m = model(o, x, y);
            e.r = m[W+3:4];
            e.f = m[3:0];
            e.c = (o == OP_MUL) ? cyc + W + 1 : cyc + 1;
            q.push_back(e);
            if (o == OP_MUL) mul_at = cyc;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 100 && q.size() > 0; i++) tick();
        check("drain_empty", q.size(), 0);
        tick();
    endtask

    logic [W-1:0] prev_r;
    logic [3:0]   prev_f;
    exp_t         got;

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    got = q.pop_front();
                    check("result", result, got.r);
                    check("flags", flags, got.f);
                    check("done_cycle", cyc, got.c);
                end
            end else begin
                check("result_hold", {prev_r, prev_f}, {result, flags});
                if (q.size() > 0 && q[0].c < cyc) begin
                    check("missing_done", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
        prev_r = result;
        prev_f = flags;
    end

    logic seen_busy_n = 1'b0;
    always @(negedge clk) if (busy_n) seen_busy_n = 1'b1;

    int k;

    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        reset = 1'b0;
        tick();

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        issue(OP_SUB, 32'd5, 32'd5);
        issue(OP_SUB, 32'd3, 32'd5);
        repeat (2) tick();

        issue(OP_AND, 32'hF0F0_F0F0, 32'h4);
        issue(OP_ORR, 32'hF0F0_F0F0, 32'h4);
        issue(OP_EOR, 32'hF0F0_F0F0, 32'h4);
        issue(OP_LSL, 32'hF0F0_F0F0, 32'h4);
        issue(OP_LSR, 32'hF0F0_F0F0, 32'h4);
        repeat (2) tick();

        k = cyc;
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        check("mul_busy_first", busy, 1);
        repeat (4) tick();
        issue(OP_ADD, 32'd1, 32'd1);
        while (cyc < k + W) tick();
        check("mul_busy_last", busy, 1);
        tick();
        check("mul_busy_fall", busy, 0);
        issue(OP_MUL, 32'd7, 32'd6);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] x, y;
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 5))
                0: x = 32'h7FFF_FFFF;
                1: y = 32'h8000_0000;
                2: y = x;
                default: ;
            endcase
            issue(3'($urandom_range(0, 7)), x, y);
        end
        drain();

        issue(OP_ADD, 32'd1, 32'd2);
        repeat (2) tick();
        k = cyc;
        issue(OP_MUL, 32'd123, 32'd456);
        while (cyc < k + 10) tick();
        #2 reset = 1'b1;
        #1;
        check("midmul_rst_busy", busy, 0);
        check("midmul_rst_done", done, 0);
        check("midmul_rst_result", result, 0);
        check("midmul_rst_flags", flags, 0);
        q.delete();
        mul_at = -1000;
        tick();
        reset = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1);
        drain();

        start_n = 1'b1; op_n = OP_MUL; a_n = 32'd7; b_n = 32'd6;
        tick();
        start_n = 1'b0;
        check("nomul_done", done_n, 1);
        check("nomul_result", result_n, 0);
        check("nomul_flags", flags_n, 4'b0100);
        tick();
        check("nomul_done_pulse", done_n, 0);
        check("nomul_busy_never", seen_busy_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
